// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared funct3 encodings, LSU state type and lane helpers
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DATA = 2'd2,
    DONE      = 2'd3
  } lsu_state_t;

  // Trap anything memory can't service natively; pass-through ops never fault on size.
  function automatic logic access_fault(input logic       is_load,
                                        input logic       is_store,
                                        input logic [2:0] f3,
                                        input logic [1:0] addr_lo);
    logic fault;
    fault = 1'b0;
    if (is_load && is_store) begin
      fault = 1'b1;
    end else if (is_load || is_store) begin
      case (f3)
        F3_B, F3_BU: fault = 1'b0;
        F3_H, F3_HU: fault = addr_lo[0];
        F3_W:        fault = (addr_lo != 2'b00);
        default:     fault = 1'b1;
      endcase
    end
    return fault;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << addr_lo;
      2'b01:   be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] data);
    logic [31:0] wdata;
    case (f3[1:0])
      2'b00:   wdata = {4{data[7:0]}};
      2'b01:   wdata = {2{data[15:0]}};
      default: wdata = data;
    endcase
    return wdata;
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// rtl/load_store_unit_load_align.sv - picks the addressed byte/half from a load word and extends it
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    data = {{24{byte_v[7]}}, byte_v};
      F3_BU:   data = {24'h0, byte_v};
      F3_H:    data = {{16{half_v[15]}}, half_v};
      F3_HU:   data = {16'h0, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding RV32I load/store stage with registered writeback
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_result,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_is_load,
  input  logic            ex_is_store,
  input  logic [4:0]      ex_rd,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_fault
);

  lsu_state_t      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [4:0]      rd_q, rd_d;
  logic            is_store_q, is_store_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            wb_we_q, wb_we_d;
  logic            wb_fault_q, wb_fault_d;

  logic [XLEN-1:0] align_data;
  logic            fault;
  logic            mem_op;

  load_align u_load_align (
    .rdata   (mem_rdata),
    .addr_lo (addr_q[1:0]),
    .funct3  (funct3_q),
    .data    (align_data)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    funct3_d   = funct3_q;
    rd_d       = rd_q;
    is_store_d = is_store_q;
    wb_data_d  = wb_data_q;
    wb_we_d    = wb_we_q;
    wb_fault_d = wb_fault_q;

    mem_op = ex_is_load || ex_is_store;
    fault  = access_fault(ex_is_load, ex_is_store, ex_funct3, ex_result[1:0]);

    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          rd_d       = ex_rd;
          funct3_d   = ex_funct3;
          is_store_d = ex_is_store;
          wb_fault_d = fault;
          if (fault || !mem_op) begin
            // Faulted ops never touch the bus, so leave the memory-side registers quiet.
            wb_data_d = fault ? '0 : ex_result;
            wb_we_d   = !fault && (ex_rd != 5'd0);
            state_d   = DONE;
          end else begin
            addr_d    = ex_result;
            be_d      = ex_is_store ? store_be(ex_funct3, ex_result[1:0]) : 4'b0000;
            wdata_d   = ex_is_store ? store_wdata(ex_funct3, ex_store_data) : '0;
            wb_data_d = '0;
            wb_we_d   = 1'b0;
            state_d   = REQ;
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          if (is_store_q) begin
            state_d = DONE;
          end else if (mem_rvalid) begin
            wb_data_d = align_data;
            wb_we_d   = (rd_q != 5'd0);
            state_d   = DONE;
          end else begin
            state_d = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        if (mem_rvalid) begin
          wb_data_d = align_data;
          wb_we_d   = (rd_q != 5'd0);
          state_d   = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= 4'b0000;
      funct3_q   <= 3'b000;
      rd_q       <= 5'd0;
      is_store_q <= 1'b0;
      wb_data_q  <= '0;
      wb_we_q    <= 1'b0;
      wb_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      funct3_q   <= funct3_d;
      rd_q       <= rd_d;
      is_store_q <= is_store_d;
      wb_data_q  <= wb_data_d;
      wb_we_q    <= wb_we_d;
      wb_fault_q <= wb_fault_d;
    end
  end

  // Bus and writeback strobes decode straight from state so reset drops them without a clock.
  assign ex_ready  = (state_q == IDLE);
  assign mem_req   = (state_q == REQ);
  assign mem_we    = mem_req && is_store_q;
  assign mem_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign wb_valid  = (state_q == DONE);
  assign wb_we     = wb_valid && wb_we_q;
  assign wb_fault  = wb_valid && wb_fault_q;
  assign wb_rd     = rd_q;
  assign wb_data   = wb_data_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage directly downstream of the execute-stage ALU in the RV32I core. Takes the ALU result as the effective address (or pass-through result), drives a single-outstanding request/grant/response data-memory port for loads and stores, aligns and sign/zero-extends load data, and presents one registered writeback beat per accepted operation. Misaligned or illegal-size accesses are trapped locally and never reach memory.

## Interface
- XLEN, 32: datapath width; only 32 supported.
- clk  in  1  core clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- ex_valid  in  1  execute stage presents an operation.
- ex_ready  out  1  unit can accept; high only in IDLE.
- ex_result  in  32  ALU result: effective address for loads/stores, writeback value otherwise.
- ex_store_data  in  32  rs2 value for stores.
- ex_funct3  in  3  access size/signedness: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ex_is_load / ex_is_store  in  1 each  memory op select; both low means pass-through; both high is illegal.
- ex_rd  in  5  destination register.
- mem_req  out  1  request valid; held until granted.
- mem_we  out  1  1 = store.
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- mem_wdata  out  32  lane-replicated store data.
- mem_be  out  4  byte enables (stores; 4'b0000 on loads).
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  load data valid this cycle.
- mem_rdata  in  32  load data word.
- wb_valid  out  1  one-cycle writeback pulse.
- wb_we  out  1  register-file write enable (0 for stores and faults, 0 when rd = 0).
- wb_rd  out  5  destination register.
- wb_data  out  32  writeback value.
- wb_fault  out  1  misaligned or illegal access; accompanies wb_valid.

## Operation
- States: IDLE, REQ, WAIT_DATA, DONE.
- IDLE: accept on ex_valid; latch address, data, funct3, rd, op type. Pass-through or fault -> DONE; memory op -> REQ.
- Fault: H/HU with addr[0]=1, W with addr[1:0]≠0, funct3 ∈ {011,110,111} on a memory op, or load and store both high.
- REQ: mem_req=1, outputs stable until mem_gnt. Store + gnt -> DONE. Load + gnt -> WAIT_DATA, or DONE directly if mem_rvalid is high in the same cycle.
- WAIT_DATA: wait for mem_rvalid; capture aligned data -> DONE.
- DONE: wb_valid=1 for one cycle -> IDLE.
- Store lanes: SB be=1<<addr[1:0], wdata={4{b}}; SH be=addr[1]?1100:0011, wdata={2{h}}; SW be=1111.
- Load extract: byte at addr[1:0], half at addr[1]; B/H sign-extend, BU/HU zero-extend.
- wb_data: pass-through = ex_result; load = extended data; store/fault = 0.
- mem_rvalid outside WAIT_DATA/REQ is ignored; mem_gnt outside REQ is ignored.

## Timing
- Reset values: state IDLE, ex_ready=1, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, wb_fault=0.
- Accept at edge N. Pass-through and fault: wb_valid in cycle N+1.
- Memory: mem_req high from N+1. Store granted in cycle G: wb_valid in G+1. Load data in cycle R ≥ G: wb_valid in R+1.
- Single outstanding op; ex_ready low from N+1 until the cycle after wb_valid.
- Reset mid-transaction: mem_req drops asynchronously, and the operation is discarded with no writeback. Any later rvalid is ignored.

## Structure
- Shared core package: funct3 size constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the lsu_state_t enum.
- Sub-module load_align (combinational): mem_rdata, addr[1:0], funct3 in; 32-bit extended value out.

## Test plan
- Pass-through: ex_result=0x1234_5678, rd=5 -> wb_valid at N+1, wb_data=0x1234_5678, wb_we=1, no mem_req.
- SB: addr 0x1003, data 0x0000_00AB, gnt immediate -> mem_addr=0x1000, be=1000, wdata=0xABAB_ABAB, wb_we=0.
- LB vs LBU: addr 0x2001, rdata=0x0000_8000 -> LB wb_data=0xFFFF_FF80; LBU wb_data=0x0000_0080.
- Misaligned LW: addr 0x3002 -> no mem_req, wb_fault=1, wb_we=0 at N+1.
- Stalled memory: gnt after 3 cycles, rvalid 2 cycles later, LH addr 0x4002, rdata=0x7FFF_0000 -> req/addr stable throughout, wb_data=0x0000_7FFF. Also cover the same-cycle gnt+rvalid case.
- Reset while in WAIT_DATA: mem_req=0 immediately, a subsequent rvalid produces no wb_valid, and ex_ready=1 after reset.
